// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 keyboard receiver decoding WASD/arrow keys into two player directions.
// Optional odd-parity enforcement is enabled by defining PS2_PARITY_CHECK_EN.
`timescale 1ns/1ps

package ps2_direction_decoder_pkg;
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;
endpackage

module ps2_direction_decoder
  import ps2_direction_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output dir_t       d1,
  output dir_t       d2,
  output logic       game_reset,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_prev_q;
  state_t        state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          byte_valid_q, frame_error_q;
  logic [7:0]    byte_data_q;
  logic          ext_q, ext_d, brk_q, brk_d;
  dir_t          d1_q, d1_d, d2_q, d2_d;
  logic          game_reset_q, game_reset_d;
  logic          fall, rx_bit, parity_ok, accept, reject;

  // Synchronisers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign rx_bit = data_sync_q[1];

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{shift_q, parity_q};
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    tmo_cnt_d = tmo_cnt_q;
    accept    = 1'b0;
    reject    = 1'b0;
    if (fall) begin
      tmo_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_bit) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {rx_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = rx_bit;
          state_d  = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if (rx_bit && parity_ok) accept = 1'b1;
          else                     reject = 1'b1;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      // An edge on the same cycle wins because this branch only runs without one.
      if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
        reject    = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      shift_q       <= 8'h00;
      bit_cnt_q     <= 3'd0;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      byte_valid_q  <= 1'b0;
      byte_data_q   <= 8'h00;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      byte_valid_q  <= accept;
      frame_error_q <= reject;
      if (accept) byte_data_q <= shift_q;
    end
  end

  // Scan-code decode runs one cycle behind the byte pulse.
  always_comb begin
    ext_d        = ext_q;
    brk_d        = brk_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    game_reset_d = game_reset_q;
    if (byte_valid_q) begin
      case (byte_data_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
          if (!ext_q) begin
            case (byte_data_q)
              8'h1D: if (!brk_q) d1_d = DIR_UP;
              8'h1B: if (!brk_q) d1_d = DIR_DOWN;
              8'h1C: if (!brk_q) d1_d = DIR_LEFT;
              8'h23: if (!brk_q) d1_d = DIR_RIGHT;
              8'h5A: game_reset_d = ~brk_q;
              default: ;
            endcase
          end else begin
            case (byte_data_q)
              8'h75: if (!brk_q) d2_d = DIR_UP;
              8'h72: if (!brk_q) d2_d = DIR_DOWN;
              8'h6B: if (!brk_q) d2_d = DIR_LEFT;
              8'h74: if (!brk_q) d2_d = DIR_RIGHT;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      d1_q         <= DIR_RIGHT;
      d2_q         <= DIR_LEFT;
      game_reset_q <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      game_reset_q <= game_reset_d;
    end
  end

  assign d1          = d1_q;
  assign d2          = d2_q;
  assign game_reset  = game_reset_q;
  assign byte_valid  = byte_valid_q;
  assign byte_data   = byte_data_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - randomized self-checking bench for ps2_direction_decoder.
`timescale 1ns/1ps

module tb_ps2_direction_decoder;
  import ps2_direction_decoder_pkg::*;

  localparam int TMO = 100;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       ps2_clk;
  logic       ps2_data;
  dir_t       d1, d2;
  logic       game_reset, byte_valid, frame_error;
  logic [7:0] byte_data;

  int checks   = 0;
  int failures = 0;

  logic [1:0] m_d1, m_d2;
  logic       m_gr, m_ext, m_brk;

  ps2_direction_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .d1(d1), .d2(d2), .game_reset(game_reset), .byte_valid(byte_valid),
    .byte_data(byte_data), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_d1 = DIR_RIGHT; m_d2 = DIR_LEFT; m_gr = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
  endtask

  // Byte-level keyboard semantics: prefixes set flags, any other byte is a key event.
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_ext && b == 8'h5A) m_gr = !m_brk;
      if (!m_brk) begin
        if (!m_ext) begin
          if (b == 8'h1D) m_d1 = DIR_UP;
          if (b == 8'h1B) m_d1 = DIR_DOWN;
          if (b == 8'h1C) m_d1 = DIR_LEFT;
          if (b == 8'h23) m_d1 = DIR_RIGHT;
        end else begin
          if (b == 8'h75) m_d2 = DIR_UP;
          if (b == 8'h72) m_d2 = DIR_DOWN;
          if (b == 8'h6B) m_d2 = DIR_LEFT;
          if (b == 8'h74) m_d2 = DIR_RIGHT;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_d1"}, d1, m_d1);
    check_eq({tag, "_d2"}, d2, m_d2);
    check_eq({tag, "_gr"}, game_reset, m_gr);
  endtask

  // Drives one full frame; stop-bit edge is driven at a negedge, so E+1 is the third posedge after it.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] bits;
    logic        acc;
    int          gap;
    bits = {stop, par, b, 1'b0};
`ifdef PS2_PARITY_CHECK_EN
    acc = stop && (^{b, par});
`else
    acc = stop;
`endif
    for (int i = 0; i < 11; i++) begin
      gap = $urandom_range(3, 6);
      @(negedge clock);
      ps2_data = bits[i];
      repeat (gap) @(negedge clock);
      ps2_clk = 1'b0;
      if (i == 10) begin
        repeat (3) @(posedge clock);
        #1;
        check_eq("byte_valid", byte_valid, acc);
        check_eq("frame_error", frame_error, !acc);
        if (acc) check_eq("byte_data", byte_data, b);
        check_outputs("pre");
        if (acc) model_byte(b);
        @(posedge clock);
        #1;
        check_eq("bv_pulse", byte_valid, 1'b0);
        check_outputs("post");
      end else begin
        repeat (gap) @(negedge clock);
      end
      @(negedge clock);
      ps2_clk = 1'b1;
    end
    @(negedge clock);
    ps2_data = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  // Start bit plus n data bits; leaves ps2_clk low after the last falling edge.
  task automatic send_partial(input logic [7:0] b, input int n);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i <= n; i++) begin
      @(negedge clock);
      ps2_data = bits[i];
      repeat (4) @(negedge clock);
      ps2_clk = 1'b0;
      if (i != n) begin
        repeat (4) @(negedge clock);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1);
  endtask

  initial begin
    int cyc;
    int errs;
    logic [7:0] pool [11];
    logic [7:0] b;
    logic       par, stop;
    pool = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A, 8'hE0, 8'hF0};

    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check_outputs("rst");
    check_eq("rst_bv", byte_valid, 1'b0);
    check_eq("rst_bd", byte_data, 8'h00);
    check_eq("rst_fe", frame_error, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    send_frame(8'h1D, 1'b1, 1'b1);
    check_eq("w_up", d1, DIR_UP);
    send_good(8'hE0); send_good(8'h6B);
    check_eq("left_d2", d2, DIR_LEFT);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h6B);
    check_eq("brk_d2", d2, DIR_LEFT);
    check_eq("brk_d1", d1, DIR_UP);
    send_good(8'h5A);
    check_eq("gr_on", game_reset, 1'b1);
    send_good(8'hF0); send_good(8'h5A);
    check_eq("gr_off", game_reset, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b1);
    send_frame(8'h1B, 1'b1, 1'b0);

    send_partial(8'h23, 3);
    cyc = 0;
    while (cyc < 300 && frame_error !== 1'b1) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check_eq("tmo_latency", cyc, TMO + 3);
    @(negedge clock);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(negedge clock);
    send_good(8'h1C);
    send_good(8'h23);
    check_eq("tmo_recover", d1, DIR_RIGHT);

    send_good(8'h1D);
    send_partial(8'h1B, 5);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check_eq("midrst_bv", byte_valid, 1'b0);
    check_eq("midrst_bd", byte_data, 8'h00);
    errs = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) reset_n = 1'b1;
      @(posedge clock);
      #1;
      if (frame_error) errs++;
    end
    check_eq("midrst_no_fe", errs, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 11) == 11) b = 8'($urandom);
      else b = pool[$urandom_range(0, 10)];
      par  = ($urandom_range(0, 7) == 0) ? ^b : ~^b;
      stop = ($urandom_range(0, 9) != 0);
      send_frame(b, par, stop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
